// File: rtl/ibus_responder.sv
// Instruction-bus slave with a one-entry 64-bit line buffer in front of a handshaked
// backing memory. Hits and misaligned fetches answer in one cycle; misses fill the buffer.

package ibus_pkg;
  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
endpackage

module ibus_responder
  import ibus_pkg::*;
#(
  parameter bit          BUF_EN    = 1'b1,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  ibus_req_t   ibus_req,
  output ibus_resp_t  ibus_resp,
  input  logic        inval,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {StIdle, StMemReq, StMemWait, StResp} state_e;

  state_e      state_q, state_d;
  // Byte-offset bits [1:0] only matter at lookup time, so they are not kept.
  logic [63:2] req_addr_q, req_addr_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        misal_q, misal_d;
  logic        buf_valid_q, buf_valid_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;

  logic misal_in;
  logic lookup_hit;

  assign misal_in   = (ibus_req.addr[1:0] != 2'b00);
  assign lookup_hit = BUF_EN && buf_valid_q && (buf_tag_q == ibus_req.addr[63:3]) && !inval;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      req_addr_q  <= '0;
      resp_data_q <= '0;
      misal_q     <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      resp_data_q <= resp_data_d;
      misal_q     <= misal_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ibus_req.valid) begin
          state_d = (misal_in || lookup_hit) ? StResp : StMemReq;
        end
      end
      StMemReq:  if (mem_req_ready) state_d = StMemWait;
      StMemWait: if (mem_resp_valid) state_d = StResp;
      StResp:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    req_addr_d  = req_addr_q;
    resp_data_d = resp_data_q;
    misal_d     = misal_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;

    if (state_q == StIdle && ibus_req.valid) begin
      req_addr_d = ibus_req.addr[63:2];
      misal_d    = misal_in;
      if (misal_in) begin
        resp_data_d = NOP_INSTR;
      end else if (lookup_hit) begin
        resp_data_d = ibus_req.addr[2] ? buf_data_q[63:32] : buf_data_q[31:0];
      end
    end

    if (state_q == StMemWait && mem_resp_valid) begin
      resp_data_d = req_addr_q[2] ? mem_resp_data[63:32] : mem_resp_data[31:0];
      if (BUF_EN) begin
        buf_data_d  = mem_resp_data;
        buf_tag_d   = req_addr_q[63:3];
        buf_valid_d = 1'b1;
      end
    end

    // Invalidate overrides a simultaneous fill.
    if (inval) begin
      buf_valid_d = 1'b0;
    end
  end

  always_comb begin
    mem_req_valid     = (state_q == StMemReq);
    mem_req_addr      = {req_addr_q[63:3], 3'b000};
    ibus_resp.addr_ok = (state_q == StResp);
    ibus_resp.data_ok = (state_q == StResp);
    ibus_resp.data    = resp_data_q;
    fetch_misaligned  = (state_q == StResp) && misal_q;
  end

endmodule

// File: doc/ibus_responder.md
# ibus_responder

Slave end of the instruction bus. It accepts `ibus_req_t` fetch requests from the fetch stage and returns `ibus_resp_t` responses carrying one 32-bit instruction. It keeps a one-entry 64-bit line buffer: a hit answers in one cycle, and a miss fetches the aligned doubleword from a handshaked backing-memory port. It sits between the fetch stage and the instruction memory/bus bridge.

## Interface
Parameters:
- `BUF_EN`, default 1: 1 enables the line buffer; 0 sends every fetch to memory.
- `NOP_INSTR`, default 32'h0000_0013: data returned for a misaligned fetch.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ibus_req`  in  `ibus_req_t`  fields `valid` (1) and `addr` (64).
- `ibus_resp`  out  `ibus_resp_t`  fields `addr_ok` (1), `data_ok` (1) and `data` (32).
- `inval`  in  1  line-buffer invalidate (fence.i / flush), single-cycle pulse.
- `mem_req_valid`  out  1  backing-memory read request.
- `mem_req_addr`  out  64  doubleword-aligned read address, `{addr[63:3],3'b0}`.
- `mem_req_ready`  in  1  memory accepts the request this cycle.
- `mem_resp_valid`  in  1  read data valid, one-cycle pulse.
- `mem_resp_data`  in  64  read doubleword.
- `fetch_misaligned`  out  1  one-cycle pulse on a misaligned response.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
- **IDLE.** At a clock edge with `ibus_req.valid=1`, latch `addr` into `req_addr`.
  - If `addr[1:0]!=0`: go to RESP with data=`NOP_INSTR` and set the misaligned flag.
  - Else if `BUF_EN`, the buffer is valid, `buf_tag==addr[63:3]` and `inval=0`: hit; select the half by `addr[2]` (0 selects `[31:0]`, 1 selects `[63:32]`) and go to RESP.
  - Else: miss; go to MEM_REQ.
- **MEM_REQ.** `mem_req_valid=1` and `mem_req_addr` is aligned from `req_addr`. At an edge with `mem_req_ready=1`, go to MEM_WAIT.
- **MEM_WAIT.** At an edge with `mem_resp_valid=1`:
  - capture the half selected by `req_addr[2]` into the response register;
  - if `BUF_EN`, write `buf_data=mem_resp_data`, `buf_tag=req_addr[63:3]` and `buf_valid=1`;
  - go to RESP.
- **RESP.** `addr_ok=data_ok=1` for exactly one cycle, with `data` from the response register. `fetch_misaligned=1` in this cycle only for a misaligned request. Return to IDLE unconditionally.
- **inval.**
  - Clears `buf_valid` at the edge where it is sampled, in any state.
  - `inval` together with a fill in MEM_WAIT: the requester still gets the fetched data, but `buf_valid` ends at 0 (inval wins).
  - `inval` together with an IDLE lookup: the lookup is treated as a miss.
- Inputs ignored outside their states:
  - `mem_resp_valid` in IDLE, MEM_REQ or RESP is dropped.
  - `mem_req_ready` outside MEM_REQ is ignored.
  - `ibus_req` outside IDLE is ignored; the latched `req_addr` governs the response even if `ibus_req.addr` changes.
- Requester rule: it holds `valid` and `addr` until it sees `addr_ok & data_ok`. If `valid` is still high in the IDLE cycle after RESP, that is a new request and is served again.

## Timing
- Reset values:
  - FSM=IDLE;
  - all `ibus_resp` fields 0;
  - `mem_req_valid=0`, `mem_req_addr=0`, `fetch_misaligned=0`;
  - `buf_valid=0` and `req_addr=0`.
- Reset mid-operation aborts any pending memory transaction. A late `mem_resp_valid` after reset is discarded (rule above).
- Latency, counting from the edge that samples `valid`:
  - hit or misaligned: response in the next cycle (1 cycle);
  - miss: `mem_req_valid` rises in the next cycle; the response comes 1 cycle after the `mem_resp_valid` edge.
- Outputs are registered. `ibus_resp` and `mem_req_*` have no combinational path from inputs.
- Back-to-back requests: minimum 2 cycles per fetch (RESP then IDLE sampling).
- The two 32-bit halves of the doubleword share one tag, so sequential PCs `8k` and `8k+4` cost one miss and then one hit.

## Test plan
- **Cold miss.** Reset; `valid=1`, `addr=0x8000_0000`; memory ready after 2 cycles and returns `0x0000_0093_0000_0013` after 3 more.
  - Expect `mem_req_addr=0x8000_0000`, then `data=0x0000_0013` with `addr_ok=data_ok=1` for one cycle.
- **Hit on the other half.** Continue with `addr=0x8000_0004`.
  - Expect no `mem_req_valid`, and `data=0x0000_0093` one cycle after `valid` is sampled.
- **Misaligned.** `addr=0x8000_0002`.
  - Expect `data=0x0000_0013`, `fetch_misaligned=1` for one cycle, and no memory request.
- **Invalidate.** After the fill at `0x8000_0000`, pulse `inval` together with `valid` at `addr=0x8000_0004`.
  - Expect a miss and a new `mem_req_addr=0x8000_0000`.
  - Separately, with `inval` during MEM_WAIT: data is still returned and the next fetch of the same line misses.
- **Reset mid-fetch.** Assert `rst` in MEM_WAIT, then deliver `mem_resp_valid` in IDLE.
  - Expect all outputs 0, no response, and `buf_valid=0` (a following fetch of the same address misses).
- **`BUF_EN=0`.** Two fetches to `0x8000_0000`/`0x8000_0004`.
  - Expect two memory requests, both to `0x8000_0000`.
